// File: rtl/seg_scan_ctrl_if.sv
// Display scan bus: digit/dp input with load strobe, decoder and anode outputs.
// Parameterised by digit count so widths track the controller.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic [3:0]              bcd_out;
  logic                    dp_out;
  logic [N_DIGITS-1:0]     an_out;
  logic [2:0]              digit_idx;
  logic                    frame_done;

  modport master (
    output en, load, digits_in, dp_in,
    input  bcd_out, dp_out, an_out, digit_idx, frame_done
  );

  modport slave (
    input  en, load, digits_in, dp_in,
    output bcd_out, dp_out, an_out, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-seg scan controller: double-buffered digits, dead-time blanking.
// Define LZB_EN to blank leading zeros (mask latched at frame start).
module seg_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input logic         clk,
  input logic         rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [DW-1:0]       pend_q, pend_d;
  logic [DW-1:0]       act_q, act_d;
  logic [N_DIGITS-1:0] pdp_q, pdp_d;
  logic [N_DIGITS-1:0] adp_q, adp_d;
  logic                pv_q, pv_d;
  logic [3:0]          bcd_q, bcd_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [2:0]          didx_q, didx_d;
  logic                fd_q, fd_d;
  logic                fstart;
  logic [3:0]          dig;
  logic                dsel;
  logic                bsel;
`ifdef LZB_EN
  logic [N_DIGITS-1:0] lzb_q, lzb_d;
  logic                zero_above;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    pdp_d   = pdp_q;
    pv_d    = pv_q;
    act_d   = act_q;
    adp_d   = adp_q;
    fstart  = 1'b0;
`ifdef LZB_EN
    lzb_d      = lzb_q;
    zero_above = 1'b1;
`endif

    if (bus.load) begin
      pend_d = bus.digits_in;
      pdp_d  = bus.dp_in;
      pv_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = BLANK;
          idx_d   = 3'd0;
          cnt_d   = '0;
          fstart  = 1'b1;
        end
      end
      default: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
          cnt_d   = '0;
          state_d = BLANK;
          if (idx_q == 3'(N_DIGITS - 1)) begin
            idx_d  = 3'd0;
            fstart = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d < CW'(BLANK_CYC)) ? BLANK : ON;
        end
      end
    endcase

    // A load coinciding with frame start goes straight to the active copy
    if (fstart) begin
      if (bus.load) begin
        act_d = bus.digits_in;
        adp_d = bus.dp_in;
      end else if (pv_q) begin
        act_d = pend_q;
        adp_d = pdp_q;
      end
      pv_d = 1'b0;
`ifdef LZB_EN
      lzb_d = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
        zero_above = zero_above && (act_d[4*i +: 4] == 4'h0);
        lzb_d[i]   = zero_above;
      end
`endif
    end

    dig  = 4'h0;
    dsel = 1'b0;
    bsel = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_d == 3'(i)) begin
        dig  = act_d[4*i +: 4];
        dsel = adp_d[i];
`ifdef LZB_EN
        bsel = lzb_d[i];
`endif
      end
    end

    bcd_d  = 4'hF;
    dp_d   = 1'b1;
    an_d   = '1;
    didx_d = 3'd0;
    if (state_d != IDLE) begin
      bcd_d  = bsel ? 4'hF : dig;
      dp_d   = ~dsel;
      didx_d = idx_d;
      // A set decimal point keeps a blanked digit's anode lit
      if (state_d == ON && (!bsel || dsel))
        an_d = ~(N_DIGITS'(1) << idx_d);
    end
    fd_d = (state_d == ON) &&
           (cnt_d == CW'(SCAN_DIV - 1)) &&
           (idx_d == 3'(N_DIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      pend_q  <= '0;
      pdp_q   <= '0;
      pv_q    <= 1'b0;
      act_q   <= '0;
      adp_q   <= '0;
      bcd_q   <= 4'hF;
      dp_q    <= 1'b1;
      an_q    <= '1;
      didx_q  <= 3'd0;
      fd_q    <= 1'b0;
`ifdef LZB_EN
      lzb_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      pv_q    <= pv_d;
      act_q   <= act_d;
      adp_q   <= adp_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      didx_q  <= didx_d;
      fd_q    <= fd_d;
`ifdef LZB_EN
      lzb_q   <= lzb_d;
`endif
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.digit_idx  = didx_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: N=4, SCAN_DIV=8, BLANK_CYC=2.
// Expected per-cycle outputs are queued with stimulus, popped on negedge.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS (4),
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] bcd;
    logic       dp;
    logic [3:0] an;
    logic [2:0] idx;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

`ifdef LZB_EN
  localparam logic [3:0] ZMASK = 4'b1110;
`else
  localparam logic [3:0] ZMASK = 4'b0000;
`endif

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.bcd = 4'hF;
      e.dp  = 1'b1;
      e.an  = 4'hF;
      e.idx = 3'd0;
      e.fd  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // First n cycles of a frame; bl marks digits expected to be blanked
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] bl, input int n);
    exp_t e;
    int   s;
    int   k;
    for (int c = 0; c < n; c++) begin
      s     = c / 8;
      k     = c % 8;
      e.bcd = bl[s] ? 4'hF : d[s*4 +: 4];
      e.dp  = ~p[s];
      e.an  = 4'hF;
      if (k >= 2 && (!bl[s] || p[s]))
        e.an = ~(4'b0001 << s);
      e.idx = 3'(s);
      e.fd  = (s == 3 && k == 7);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("bcd", {4'h0, bus.bcd_out}, {4'h0, mon_e.bcd});
      chk("dp", {7'h0, bus.dp_out}, {7'h0, mon_e.dp});
      chk("an", {4'h0, bus.an_out}, {4'h0, mon_e.an});
      chk("idx", {5'h0, bus.digit_idx}, {5'h0, mon_e.idx});
      chk("fdone", {7'h0, bus.frame_done}, {7'h0, mon_e.fd});
    end
  end

  initial begin
    bus.en        = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    ticks(2);
    rst = 1'b0;

    // reset state, then enable with bypass load at frame start
    push_idle(1);
    push_frame(16'h1234, 4'b0000, 4'b0000, 32);
    push_frame(16'h1234, 4'b0000, 4'b0000, 32);
    bus.en        = 1'b1;
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    tick();
    bus.load = 1'b0;

    // mid-frame load during slot 1 lands at the next frame
    ticks(41);
    push_frame(16'h5678, 4'b0000, 4'b0000, 32);
    bus.load      = 1'b1;
    bus.digits_in = 16'h5678;
    tick();
    bus.load = 1'b0;

    // load in the last cycle so it is sampled at frame start
    ticks(53);
    push_frame(16'h2468, 4'b1010, 4'b0000, 20);
    bus.load      = 1'b1;
    bus.digits_in = 16'h2468;
    bus.dp_in     = 4'b1010;
    tick();
    bus.load = 1'b0;

    // drop en during slot 2 ON
    ticks(19);
    push_idle(2);
    bus.en = 1'b0;
    ticks(2);
    push_frame(16'h2468, 4'b1010, 4'b0000, 12);
    bus.en = 1'b1;
    tick();

    // reset mid-frame with en held high; active buffer must be zero
    ticks(11);
    push_idle(1);
    push_frame(16'h0000, 4'b0000, ZMASK, 32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(32);

`ifdef LZB_EN
    push_frame(16'h0070, 4'b0100, 4'b1100, 32);
    bus.load      = 1'b1;
    bus.digits_in = 16'h0070;
    bus.dp_in     = 4'b0100;
    tick();
    bus.load = 1'b0;
    ticks(31);
`endif

    ticks(2);
    chk("drain", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
